// File: rtl/alu_defs.sv
// Shared definitions for the ALU result path: op select codes, flag bit
// positions and the default data width.
package alu_defs;

   localparam int WIDTH_DEF = 8;

   // Op select codes applied to the 8-to-1 result mux
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;

   // Bit positions inside the 4-bit {N,Z,C,V} flag vector
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Carry and overflow are only meaningful for adder/subtractor results
   function automatic logic is_arith(input logic [2:0] sel);
      return (sel == OP_ADD) || (sel == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational N/Z/C/V derivation for one ALU result.
module alu_flag_gen
   import alu_defs::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] result,
   input  logic [2:0]       select,
   input  logic             carry,
   input  logic             ovf,
   output logic [3:0]       flags
);

   // N and Z come from the result; C and V only pass for arithmetic ops
   always_comb begin
      flags         = 4'b0000;
      flags[FLAG_N] = result[WIDTH-1];
      flags[FLAG_Z] = (result == {WIDTH{1'b0}});
      if (is_arith(select)) begin
         flags[FLAG_C] = carry;
         flags[FLAG_V] = ovf;
      end else begin
         flags[FLAG_C] = 1'b0;
         flags[FLAG_V] = 1'b0;
      end
   end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: flag generation, 2-entry skid buffer with a
// registered in_ready, and a wrapping count of completed output transfers.
module alu_result_stage
   import alu_defs::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic [2:0]       in_select,
   input  logic             in_carry,
   input  logic             in_ovf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [3:0]       out_flags,
   output logic [CNT_W-1:0] out_count
);

   logic [3:0]       new_flags_s;
   logic             in_xfer_s;
   logic             out_xfer_s;

   logic             main_valid_r;
   logic [WIDTH-1:0] main_result_r;
   logic [3:0]       main_flags_r;
   logic             skid_valid_r;
   logic [WIDTH-1:0] skid_result_r;
   logic [3:0]       skid_flags_r;
   logic             in_ready_r;
   logic [CNT_W-1:0] count_r;

   logic             main_valid_s;
   logic [WIDTH-1:0] main_result_s;
   logic [3:0]       main_flags_s;
   logic             skid_valid_s;
   logic [WIDTH-1:0] skid_result_s;
   logic [3:0]       skid_flags_s;

   alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
      .result (in_result),
      .select (in_select),
      .carry  (in_carry),
      .ovf    (in_ovf),
      .flags  (new_flags_s)
   );

   assign in_xfer_s  = in_valid && in_ready_r;
   assign out_xfer_s = main_valid_r && out_ready;

   // Next-state of the two entries: drain skid into main first, otherwise
   // fill main when it is free (or freeing), else park the input in skid
   always_comb begin
      main_valid_s  = main_valid_r;
      main_result_s = main_result_r;
      main_flags_s  = main_flags_r;
      skid_valid_s  = skid_valid_r;
      skid_result_s = skid_result_r;
      skid_flags_s  = skid_flags_r;
      if (out_xfer_s && skid_valid_r) begin
         main_valid_s  = 1'b1;
         main_result_s = skid_result_r;
         main_flags_s  = skid_flags_r;
         skid_valid_s  = in_xfer_s;
         if (in_xfer_s) begin
            skid_result_s = in_result;
            skid_flags_s  = new_flags_s;
         end else begin
            skid_result_s = skid_result_r;
            skid_flags_s  = skid_flags_r;
         end
      end else if (in_xfer_s && (!main_valid_r || out_xfer_s)) begin
         main_valid_s  = 1'b1;
         main_result_s = in_result;
         main_flags_s  = new_flags_s;
      end else if (in_xfer_s) begin
         skid_valid_s  = 1'b1;
         skid_result_s = in_result;
         skid_flags_s  = new_flags_s;
      end else begin
         main_valid_s  = main_valid_r && !out_xfer_s;
      end
   end

   // Entry registers, registered in_ready and the transfer counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_r  <= 1'b0;
         main_result_r <= {WIDTH{1'b0}};
         main_flags_r  <= 4'b0000;
         skid_valid_r  <= 1'b0;
         skid_result_r <= {WIDTH{1'b0}};
         skid_flags_r  <= 4'b0000;
         in_ready_r    <= 1'b1;
         count_r       <= {CNT_W{1'b0}};
      end else begin
         main_valid_r  <= main_valid_s;
         main_result_r <= main_result_s;
         main_flags_r  <= main_flags_s;
         skid_valid_r  <= skid_valid_s;
         skid_result_r <= skid_result_s;
         skid_flags_r  <= skid_flags_s;
         in_ready_r    <= !skid_valid_s;
         if (out_xfer_s) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            count_r <= count_r;
         end
      end
   end

   assign in_ready   = in_ready_r;
   assign out_valid  = main_valid_r;
   assign out_result = main_result_r;
   assign out_flags  = main_flags_r;
   assign out_count  = count_r;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: a 16-bit-counter instance for the
// datapath and a 4-bit-counter instance for the wrap sequence.
module tb_alu_result_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_result = 8'h00;
   logic [2:0]  in_select = 3'b000;
   logic        in_carry = 1'b0;
   logic        in_ovf = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_result;
   logic [3:0]  out_flags;
   logic [15:0] out_count;

   logic        b_in_valid = 1'b0;
   logic        b_in_ready;
   logic [7:0]  b_in_result = 8'h00;
   logic        b_out_valid;
   logic        b_out_ready = 1'b0;
   logic [7:0]  b_out_result;
   logic [3:0]  b_out_flags;
   logic [3:0]  b_out_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_result_stage #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
      .in_select(in_select), .in_carry(in_carry), .in_ovf(in_ovf),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_flags(out_flags), .out_count(out_count)
   );

   alu_result_stage #(.WIDTH(8), .CNT_W(4)) dut_wrap (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_result(b_in_result),
      .in_select(3'b000), .in_carry(1'b0), .in_ovf(1'b0),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result),
      .out_flags(b_out_flags), .out_count(b_out_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_result", {24'd0, out_result}, 32'd0);
      chk("rst_out_flags", {28'd0, out_flags}, 32'd0);
      chk("rst_out_count", {16'd0, out_count}, 32'd0);
      rst_n = 1'b1;
      step();

      // Single transfer: 0x80 ADD with carry and overflow -> N,C,V
      out_ready = 1'b1; in_valid = 1'b1; in_result = 8'h80;
      in_select = 3'b000; in_carry = 1'b1; in_ovf = 1'b1;
      step();
      in_valid = 1'b0;
      chk("single_valid", {31'd0, out_valid}, 32'd1);
      chk("single_result", {24'd0, out_result}, 32'h80);
      chk("single_flags", {28'd0, out_flags}, 32'b1011);
      step();
      chk("single_count", {16'd0, out_count}, 32'd1);
      chk("single_drained", {31'd0, out_valid}, 32'd0);

      // Logic op: carry/ovf masked, only Z
      in_valid = 1'b1; in_result = 8'h00; in_select = 3'b100;
      step();
      in_valid = 1'b0;
      chk("mask_flags", {28'd0, out_flags}, 32'b0100);
      chk("mask_result", {24'd0, out_result}, 32'h00);
      step();
      chk("mask_count", {16'd0, out_count}, 32'd2);

      // Backpressure: 01, 02 accepted, 03 held
      out_ready = 1'b0; in_select = 3'b000; in_carry = 1'b0; in_ovf = 1'b0;
      in_valid = 1'b1; in_result = 8'h01;
      step();
      chk("bp_ready_after_01", {31'd0, in_ready}, 32'd1);
      in_result = 8'h02;
      step();
      chk("bp_ready_after_02", {31'd0, in_ready}, 32'd0);
      chk("bp_result_01", {24'd0, out_result}, 32'h01);
      in_result = 8'h03;
      step();
      chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_result", {24'd0, out_result}, 32'h01);
      chk("bp_hold_flags", {28'd0, out_flags}, 32'b0000);
      step();
      chk("bp_hold_result2", {24'd0, out_result}, 32'h01);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      step();
      chk("bp_drain_02", {24'd0, out_result}, 32'h02);
      chk("bp_drain_ready", {31'd0, in_ready}, 32'd1);
      chk("bp_drain_count", {16'd0, out_count}, 32'd3);
      step();
      in_valid = 1'b0;
      chk("bp_drain_03", {24'd0, out_result}, 32'h03);
      chk("bp_drain_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_drain_count2", {16'd0, out_count}, 32'd4);
      step();
      chk("bp_empty", {31'd0, out_valid}, 32'd0);
      chk("bp_count_final", {16'd0, out_count}, 32'd5);

      // Streaming 0..19 with a logic select and carry set (C,V masked)
      in_select = 3'b010; in_carry = 1'b1; in_ovf = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1; in_result = 8'(i);
         step();
         chk("stream_valid", {31'd0, out_valid}, 32'd1);
         chk("stream_result", {24'd0, out_result}, 32'(i));
         chk("stream_flags", {28'd0, out_flags}, (i == 0) ? 32'b0100 : 32'b0000);
      end
      in_valid = 1'b0;
      step();
      chk("stream_count", {16'd0, out_count}, 32'd25);
      chk("stream_empty", {31'd0, out_valid}, 32'd0);

      // Counter wrap on the 4-bit instance: 17 transfers
      b_out_ready = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         b_in_valid = (k <= 17); b_in_result = 8'(k);
         step();
         chk("wrap_count", {28'd0, b_out_count}, 32'((k - 1) % 16));
      end
      b_in_valid = 1'b0;

      // Asynchronous reset with both entries full
      out_ready = 1'b0; in_select = 3'b000; in_carry = 1'b0; in_ovf = 1'b0;
      in_valid = 1'b1; in_result = 8'hAA;
      step();
      in_result = 8'hBB;
      step();
      in_valid = 1'b0;
      chk("full_ready", {31'd0, in_ready}, 32'd0);
      chk("full_valid", {31'd0, out_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_ready", {31'd0, in_ready}, 32'd1);
      chk("arst_count", {16'd0, out_count}, 32'd0);
      chk("arst_result", {24'd0, out_result}, 32'd0);
      chk("arst_wrap_count", {28'd0, b_out_count}, 32'd0);
      #3 rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
      step();
      chk("post_rst_valid2", {31'd0, out_valid}, 32'd0);
      chk("post_rst_count", {16'd0, out_count}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
